// File: rtl/m_axil_cmd.sv
// m_axil_cmd: single-outstanding AXI4-Lite master that converts a command stream into
// AXI-Lite reads/writes and returns one response per command, with a hung-slave timeout.
module m_axil_cmd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    axi_clock,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;

    state_t                  r_state, w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_aw_done, r_w_done, r_to;
    logic [CW-1:0]           r_cnt;
    logic [1:0]              r_resp;
    logic                    w_busy, w_hit, w_accept, w_b_hs, w_r_hs, w_expire;

    assign w_busy   = (r_state == WADDR) || (r_state == WRESP) || (r_state == RADDR) || (r_state == RDATA);
    // The counter reaches TIMEOUT on the edge closing this cycle; a B/R handshake here still wins.
    assign w_hit    = (TIMEOUT != 0) && w_busy && (r_cnt == CW'(TIMEOUT - 1));
    assign w_accept = cmd_valid & cmd_ready;
    assign w_b_hs   = (r_state == WRESP) & m_axil_bvalid;
    assign w_r_hs   = (r_state == RDATA) & m_axil_rvalid;
    assign w_expire = w_hit & ~w_b_hs & ~w_r_hs;

    assign cmd_ready      = (r_state == IDLE) & ~rst;
    assign rsp_valid      = (r_state == RESP);
    assign rsp_rdata      = r_rdata;
    assign rsp_resp       = r_resp;
    assign rsp_timeout    = r_to;
    assign m_axil_awaddr  = r_addr;
    assign m_axil_araddr  = r_addr;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_awvalid = (r_state == WADDR) & ~r_aw_done;
    assign m_axil_wvalid  = (r_state == WADDR) & ~r_w_done;
    assign m_axil_bready  = (r_state == WRESP);
    assign m_axil_arvalid = (r_state == RADDR);
    assign m_axil_rready  = (r_state == RDATA);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:         if (w_accept) w_next = cmd_we ? WADDR : RADDR;
            WADDR:        if ((r_aw_done | m_axil_awready) & (r_w_done | m_axil_wready)) w_next = WRESP;
            RADDR:        if (m_axil_arready) w_next = RDATA;
            WRESP, RDATA: if (w_b_hs | w_r_hs) w_next = RESP;
            RESP:         if (rsp_ready) w_next = IDLE;
            default:      w_next = IDLE;
        endcase
        if (w_expire) w_next = RESP;
    end

    always_ff @(posedge axi_clock) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
            r_to      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_cnt     <= '0;
            end
            if (w_busy) r_cnt <= r_cnt + CW'(1);
            if (r_state == WADDR) begin
                r_aw_done <= r_aw_done | m_axil_awready;
                r_w_done  <= r_w_done | m_axil_wready;
            end
            if (w_b_hs) begin
                r_resp  <= m_axil_bresp;
                r_rdata <= '0;
                r_to    <= 1'b0;
            end
            if (w_r_hs) begin
                r_resp  <= m_axil_rresp;
                r_rdata <= m_axil_rdata;
                r_to    <= 1'b0;
            end
            if (w_expire) begin
                r_resp  <= 2'b10;
                r_rdata <= '0;
                r_to    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_m_axil_cmd.sv
// tb_m_axil_cmd: directed and random commands against a behavioural AXI-Lite slave,
// checked against a word-memory reference model and cycle-latency rules.
module tb_m_axil_cmd;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [11:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [31:0] m_axil_wdata, m_axil_rdata;
    logic [3:0]  m_axil_wstrb;
    logic [1:0]  m_axil_bresp, m_axil_rresp;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;

    m_axil_cmd #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .TIMEOUT(16)) dut (
        .axi_clock(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
        .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid),
        .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
        .m_axil_rready(m_axil_rready)
    );

    always #5 clk = ~clk;

    int   total = 0, bad = 0, cyc = 0, acc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // slave configuration and per-command observations
    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0;
    logic        cfg_no_b = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [11:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;
    int          aw_hi, w_hi, ar_hi, first_aw, first_w, first_ar, b_cnt, addr_err;
    logic        ar_at_rsp;
    logic [31:0] smem [1024];
    logic [31:0] ref_mem [1024];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Behavioural AXI-Lite slave: decides at each falling edge, handshakes land on the next rising edge.
    initial begin : slave
        logic        p_aw, p_w, p_ar, p_b, p_r, got_aw, got_w;
        logic [11:0] p_awaddr, p_araddr, s_awaddr;
        logic [31:0] p_wdata, s_wdata;
        logic [3:0]  p_wstrb, s_wstrb;
        int          aw_wait, w_wait, ar_wait;
        {p_aw, p_w, p_ar, p_b, p_r, got_aw, got_w} = '0;
        {p_awaddr, p_araddr, s_awaddr, p_wdata, s_wdata, p_wstrb, s_wstrb} = '0;
        {aw_wait, w_wait, ar_wait} = '0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_rvalid = 0; m_axil_bresp = 0; m_axil_rresp = 0; m_axil_rdata = 0;
        for (int i = 0; i < 1024; i++) smem[i] = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                {p_aw, p_w, p_ar, p_b, p_r, got_aw, got_w} = '0;
                {aw_wait, w_wait, ar_wait} = '0;
                m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
                m_axil_bvalid = 0; m_axil_rvalid = 0;
            end else begin
                if (p_b) begin m_axil_bvalid = 0; b_cnt++; end
                if (p_r) m_axil_rvalid = 0;
                if (p_aw) begin got_aw = 1; s_awaddr = p_awaddr; end
                if (p_w) begin got_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
                if (p_ar) begin
                    m_axil_rvalid = 1; m_axil_rdata = smem[p_araddr[11:2]]; m_axil_rresp = cfg_rresp;
                end
                if (got_aw && got_w && !cfg_no_b) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) smem[s_awaddr[11:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    m_axil_bvalid = 1; m_axil_bresp = cfg_bresp; got_aw = 0; got_w = 0;
                end
                if (m_axil_awvalid) begin
                    m_axil_awready = (aw_wait >= cfg_aw_dly); aw_wait = m_axil_awready ? 0 : aw_wait + 1;
                    aw_hi++; if (first_aw < 0) first_aw = cyc;
                    if (m_axil_awaddr !== cur_addr) addr_err++;
                end else begin m_axil_awready = 0; aw_wait = 0; end
                if (m_axil_wvalid) begin
                    m_axil_wready = (w_wait >= cfg_w_dly); w_wait = m_axil_wready ? 0 : w_wait + 1;
                    w_hi++; if (first_w < 0) first_w = cyc;
                    if (m_axil_wdata !== cur_wdata || m_axil_wstrb !== cur_wstrb) addr_err++;
                end else begin m_axil_wready = 0; w_wait = 0; end
                if (m_axil_arvalid) begin
                    m_axil_arready = (ar_wait >= cfg_ar_dly); ar_wait = m_axil_arready ? 0 : ar_wait + 1;
                    ar_hi++; if (first_ar < 0) first_ar = cyc;
                    if (m_axil_araddr !== cur_addr) addr_err++;
                end else begin m_axil_arready = 0; ar_wait = 0; end
            end
            p_aw = m_axil_awvalid & m_axil_awready; p_awaddr = m_axil_awaddr;
            p_w  = m_axil_wvalid & m_axil_wready;   p_wdata = m_axil_wdata; p_wstrb = m_axil_wstrb;
            p_ar = m_axil_arvalid & m_axil_arready; p_araddr = m_axil_araddr;
            p_b  = m_axil_bvalid & m_axil_bready;
            p_r  = m_axil_rvalid & m_axil_rready;
        end
    end

    task automatic run_cmd(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int hold,
                           output logic [31:0] rd, output logic [1:0] rs, output logic to, output int lat);
        int n;
        @(negedge clk);
        cur_addr = addr; cur_wdata = wd; cur_wstrb = ws;
        aw_hi = 0; w_hi = 0; ar_hi = 0; first_aw = -1; first_w = -1; first_ar = -1; b_cnt = 0; addr_err = 0;
        cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("accept_wait", cmd_ready, 1);
        acc = cyc;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        check("rsp_wait", rsp_valid, 1);
        lat = cyc - acc; rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout; ar_at_rsp = m_axil_arvalid;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", {rsp_valid, cmd_ready, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b0, to, rs, rd});
        end
        rsp_ready = 1;
        check("cmd_ready_in_resp", cmd_ready, 0);
        @(negedge clk);
        rsp_ready = 0;
        check("cmd_ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
    endtask

    task automatic ref_write(input logic [11:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[addr[11:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd, wd;
        logic [11:0] a;
        logic [3:0]  ws;
        logic [1:0]  rs;
        logic        to, we;
        int          lat, n;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready,
                                rsp_valid, cmd_ready, rsp_timeout, rsp_resp}, 0);
        check("reset_rdata", rsp_rdata, 0);
        rst = 0;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);

        run_cmd(1, 12'h004, 32'hDEADBEEF, 4'hF, 0, rd, rs, to, lat);
        ref_write(12'h004, 32'hDEADBEEF, 4'hF);
        check("w1_latency", lat, 3);
        check("w1_aw_cycle", first_aw, acc + 1);
        check("w1_w_cycle", first_w, acc + 1);
        check("w1_rsp", {to, rs, rd}, {1'b0, 2'b00, 32'h0});
        check("w1_bcount", b_cnt, 1);
        check("w1_prot", {m_axil_awprot, m_axil_arprot}, 0);

        run_cmd(0, 12'h004, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("r1_latency", lat, 3);
        check("r1_ar_cycle", first_ar, acc + 1);
        check("r1_rsp", {to, rs, rd}, {1'b0, 2'b00, 32'hDEADBEEF});
        check("r1_addr", addr_err, 0);

        cfg_aw_dly = 4;
        run_cmd(1, 12'h010, 32'h12345678, 4'h5, 0, rd, rs, to, lat);
        ref_write(12'h010, 32'h12345678, 4'h5);
        cfg_aw_dly = 0;
        check("w2_aw_high", aw_hi, 5);
        check("w2_w_high", w_hi, 1);
        check("w2_stable", addr_err, 0);
        repeat (3) @(negedge clk);
        check("w2_bcount", b_cnt, 1);
        check("w2_rsp", {to, rs, rd}, {1'b0, 2'b00, 32'h0});

        run_cmd(0, 12'h010, 32'h0, 4'h0, 10, rd, rs, to, lat);
        check("r2_hold_data", rd, ref_mem[12'h010 >> 2]);

        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom_range(0, 1)); a = 12'($urandom_range(0, 15) * 4);
            wd = $urandom; ws = 4'($urandom_range(0, 15));
            cfg_aw_dly = $urandom_range(0, 3); cfg_w_dly = $urandom_range(0, 3); cfg_ar_dly = $urandom_range(0, 3);
            cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
            run_cmd(we, a, wd, ws, $urandom_range(0, 2), rd, rs, to, lat);
            if (we) begin
                ref_write(a, wd, ws);
                check("rnd_w_rsp", {to, rs, rd}, {1'b0, cfg_bresp, 32'h0});
                check("rnd_w_lat", lat, 3 + ((cfg_aw_dly > cfg_w_dly) ? cfg_aw_dly : cfg_w_dly));
                check("rnd_w_high", {aw_hi, w_hi}, {cfg_aw_dly + 1, cfg_w_dly + 1});
            end else begin
                check("rnd_r_rsp", {to, rs, rd}, {1'b0, cfg_rresp, ref_mem[a[11:2]]});
                check("rnd_r_lat", lat, 3 + cfg_ar_dly);
            end
            check("rnd_addr", addr_err, 0);
        end
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_bresp = 0; cfg_rresp = 0;

        cfg_ar_dly = 1000;
        run_cmd(0, 12'h020, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("to_latency", lat, 17);
        check("to_rsp", {to, rs, rd}, {1'b1, 2'b10, 32'h0});
        check("to_arvalid", ar_at_rsp, 0);
        check("to_ar_high", ar_hi, 16);
        cfg_ar_dly = 0;
        run_cmd(0, 12'h004, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("after_to_rsp", {to, rs, rd}, {1'b0, 2'b00, ref_mem[1]});
        check("after_to_lat", lat, 3);

        cfg_ar_dly = 14;
        run_cmd(0, 12'h010, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("edge_win_rsp", {to, rs, rd}, {1'b0, 2'b00, ref_mem[4]});
        check("edge_win_lat", lat, 17);

        cfg_ar_dly = 15;
        run_cmd(0, 12'h010, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("edge_late_rsp", {to, rs, rd}, {1'b1, 2'b10, 32'h0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_r_ignored", {m_axil_rvalid, m_axil_rready}, 2'b10);
        end
        cfg_ar_dly = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        cfg_no_b = 1;
        cmd_valid = 1; cmd_we = 1; cmd_addr = 12'h030; cmd_wdata = 32'hA5A5A5A5; cmd_wstrb = 4'hF;
        cur_addr = 12'h030; cur_wdata = 32'hA5A5A5A5; cur_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!m_axil_bready && n < 20) begin @(negedge clk); n++; end
        check("wresp_reached", m_axil_bready, 1);
        rst = 1;
        @(negedge clk);
        check("mid_rst_outputs", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready,
                                  m_axil_rready, rsp_valid, cmd_ready}, 0);
        rst = 0;
        cfg_no_b = 0;
        @(negedge clk);
        check("mid_rst_ready", {cmd_ready, rsp_valid}, 2'b10);
        repeat (3) @(negedge clk);
        check("mid_rst_no_rsp", rsp_valid, 0);

        run_cmd(1, 12'h030, 32'hCAFEF00D, 4'hC, 0, rd, rs, to, lat);
        ref_write(12'h030, 32'hCAFEF00D, 4'hC);
        run_cmd(0, 12'h030, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("final_read", {to, rs, rd}, {1'b0, 2'b00, ref_mem[12]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
